// File: rtl/mem_access_arbiter.sv
// Two-port (fetch/data) burst arbiter in front of a single memory port.
// Round-robin on contention, word-aligned bursts of 1/4/8/16 beats.
module mem_access_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              p0_req,
  input  logic              p0_rw,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [1:0]        p0_size,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_wack,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_rw,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [1:0]        p1_size,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_wack,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_access_size,
  output logic              mem_rw,
  output logic              mem_enable,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              port_q, port_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              prio_q, prio_d;
  logic              gnt_q, gnt_d;
  logic              rdv_q, rdv_d;

  logic              in_burst;
  logic              accept;
  logic              win;
  logic [3:0]        len_m1;
  logic [ADDR_W-1:0] win_addr;

  assign in_burst = (state_q == BURST);
  assign accept   = in_burst & ~mem_busy;
  assign win      = (p0_req & p1_req) ? prio_q : p1_req;
  assign win_addr = win ? p1_addr : p0_addr;

  // Last-beat index of the latched burst length.
  always_comb begin
    len_m1 = 4'd0;
    unique case (size_q)
      2'b00: len_m1 = 4'd0;
      2'b01: len_m1 = 4'd3;
      2'b10: len_m1 = 4'd7;
      2'b11: len_m1 = 4'd15;
    endcase
  end

  // Next-state: arbitrate in IDLE, count accepted beats, one DRAIN cycle.
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    rw_d    = rw_q;
    size_d  = size_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    gnt_d   = 1'b0;
    rdv_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (p0_req | p1_req) begin
          port_d  = win;
          rw_d    = win ? p1_rw : p0_rw;
          size_d  = win ? p1_size : p0_size;
          base_d  = {win_addr[ADDR_W-1:2], 2'b00};
          cnt_d   = 4'd0;
          prio_d  = ~win;
          gnt_d   = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        if (accept) begin
          rdv_d = ~rw_q;
          if (cnt_q == len_m1) begin
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and burst context registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      port_q  <= 1'b0;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      base_q  <= '0;
      cnt_q   <= 4'd0;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      rdv_q   <= rdv_d;
    end
  end

  logic wack;
  assign wack = accept & rw_q;

  assign mem_enable      = in_burst;
  assign mem_address     = in_burst ?
    base_q + {{(ADDR_W-6){1'b0}}, cnt_q, 2'b00} : '0;
  assign mem_data_in     = (in_burst & rw_q) ?
    (port_q ? p1_wdata : p0_wdata) : '0;
  assign mem_access_size = size_q;
  assign mem_rw          = rw_q;

  assign p0_gnt    = gnt_q & ~port_q;
  assign p0_wack   = wack & ~port_q;
  assign p0_rvalid = rdv_q & ~port_q;
  assign p0_rdata  = p0_rvalid ? mem_data_out : '0;
  assign p0_done   = (state_q == DRAIN) & ~port_q;

  assign p1_gnt    = gnt_q & port_q;
  assign p1_wack   = wack & port_q;
  assign p1_rvalid = rdv_q & port_q;
  assign p1_rdata  = p1_rvalid ? mem_data_out : '0;
  assign p1_done   = (state_q == DRAIN) & port_q;

endmodule
